sys_mem_responder: RTL and testbench
====================================

Name: sys_mem_responder

Overview:
- System-side memory responder for the data cache's Sys* bus; it is the target end of the SysStrobe/SysRW/SysAddress/SysData interface.
- Serves line refills as fixed-length read bursts and serves write-through stores as single-word writes.
- Inserts a programmable access latency.
- Sits below the dcache in the core top level; the top level owns the SysData tristate, using SysDataOut and SysDataOE from this block.

Parameters:
- DEPTH, 1024: number of 32-bit words in backing store (power of 2).
- LINE_WORDS, 4: words per cache line / read burst length (power of 2, ≥1).
- LATENCY, 3: cycles from strobe-sample cycle to first SysReady (≥1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- SysStrobe  in  1  request valid; sampled only in IDLE.
- SysRW  in  1  1 = write, 0 = read (line refill).
- SysAddress  in  32  byte address; word index = SysAddress[log2(DEPTH)+1:2], upper bits ignored (modulo DEPTH).
- SysDataIn  in  32  write data from cache; sampled with SysStrobe.
- SysDataOut  out  32  read burst data.
- SysDataOE  out  1  high only while SysDataOut carries valid read data; top level drives SysData from it.
- SysReady  out  1  read: data-valid per beat; write: one-cycle completion pulse.
- SysBusy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: state IDLE, SysReady=0, SysDataOE=0, SysDataOut=0, SysBusy=0, latency and beat counters=0. Memory contents are not cleared.
- Reset asserted mid-operation aborts the request. Any write not yet committed is discarded. Outputs follow the reset values on the next cycle.
- FSM states: IDLE, WAIT, RBURST, WCOMMIT.
- IDLE, SysStrobe=1 sampled at an edge:
  - capture word index, SysRW and SysDataIn;
  - load latency counter with LATENCY-1;
  - SysBusy=1 from the next cycle;
  - next state is WAIT, or goes directly to RBURST/WCOMMIT when LATENCY=1.
- WAIT: decrement the counter each cycle. When it reaches 0, go to RBURST if the captured RW=0, or to WCOMMIT if RW=1. Net effect: the first SysReady occurs exactly LATENCY cycles after the strobe-sample cycle.
- RBURST:
  - lasts LINE_WORDS consecutive cycles with SysReady=1 and SysDataOE=1.
  - Beat k (k=0..LINE_WORDS-1) carries mem[line_base + k].
  - line_base = captured index with its low log2(LINE_WORDS) bits cleared. The requested word's position in the line does not change the order; delivery always starts at line_base.
  - After the last beat, return to IDLE. SysReady, SysDataOE and SysBusy drop in the following cycle.
- WCOMMIT: one cycle with SysReady=1. mem[index] is updated at the end of this cycle, then return to IDLE.
- SysStrobe while SysBusy=1 is ignored; no queueing. The cache must wait for !SysBusy.
- Back-to-back: a strobe is accepted in the first IDLE cycle after completion. Minimum request spacing is LATENCY+LINE_WORDS cycles for reads and LATENCY+1 cycles for writes.
- Ordering: a read issued after a write completes always returns the written data, including for the same line.
- SysDataOut holds its last value when SysDataOE=0. Consumers must qualify it with SysReady.
- Address wrap: an index ≥ DEPTH aliases modulo DEPTH. The burst never crosses a line boundary because line_base is aligned.
- Counter widths: latency counter is $clog2(LATENCY+1) bits; beat counter is $clog2(LINE_WORDS)+1 bits.

Optional Feature:
- Macro: SYSMEM_STATS_EN.
- Defined: adds outputs rd_cnt (32, count of completed read bursts) and wr_cnt (32, count of committed writes).
  - Each counter increments on the completing cycle and wraps at 2^32.
  - Both reset to 0; an aborted request does not count.
- Undefined: these ports and their counters are absent; behaviour is otherwise identical.

Decomposition:
- Package sysbus_pkg:
  - state enum sysmem_state_t {IDLE, WAIT, RBURST, WCOMMIT};
  - default-parameter constants;
  - the SysRW encoding constants SYS_READ=0 and SYS_WRITE=1, shared with the cache.
- Sub-module sysmem_array: single-port word RAM, DEPTH×32, synchronous write.
  - Read is registered with one-cycle latency, so the read address is issued one cycle ahead of each beat.

Test Plan (LATENCY=3, LINE_WORDS=4 unless stated):
- Reset, then idle: SysReady=0, SysDataOE=0, SysBusy=0; a strobe asserted while rst=1 is ignored.
- Write 0xDEADBEEF to address 0x40 with strobe at cycle 10 -> SysReady pulse only at cycle 13. Read 0x44 at cycle 15 -> beats at cycles 18-21 carry mem[16..19], with beat 0 = 0xDEADBEEF.
- Preload mem[8..11] = 0x11, 0x22, 0x33, 0x44 and read address 0x2C (word 11) -> beats in order 0x11, 0x22, 0x33, 0x44 with SysDataOE=1 for all 4 cycles.
- Strobe repeated during WAIT and RBURST -> ignored, with exactly one burst of 4 beats. A strobe on the first IDLE cycle is accepted.
- rst pulsed during WAIT of a write of 0x5555 to 0x80 -> a later read of 0x80 returns the prior value; outputs reach reset values.
- Set LATENCY=1: SysReady appears the cycle after strobe. Read address 0x1000 with DEPTH=1024 aliases to word 0. With SYSMEM_STATS_EN, rd_cnt=2 and wr_cnt=1 after the sequence.

Source files
------------

// File: rtl/sysbus_pkg.sv
// Shared types and constants for the Sys* memory bus between the data cache and its responder.
package sysbus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RBURST  = 2'd2,
    WCOMMIT = 2'd3
  } sysmem_state_t;

  localparam int SYSMEM_DEPTH      = 1024;
  localparam int SYSMEM_LINE_WORDS = 4;
  localparam int SYSMEM_LATENCY    = 3;

  // SysRW encoding, shared with the cache side.
  localparam logic SYS_READ  = 1'b0;
  localparam logic SYS_WRITE = 1'b1;

endpackage

// File: rtl/sys_mem_responder_if.sv
// Sys* bus bundle; the cache is the master and the memory responder is the slave.
interface sys_mem_responder_if;
  logic        SysStrobe;
  logic        SysRW;
  logic [31:0] SysAddress;
  logic [31:0] SysDataIn;
  logic [31:0] SysDataOut;
  logic        SysDataOE;
  logic        SysReady;
  logic        SysBusy;

  modport master (
    output SysStrobe, SysRW, SysAddress, SysDataIn,
    input  SysDataOut, SysDataOE, SysReady, SysBusy
  );

  modport slave (
    input  SysStrobe, SysRW, SysAddress, SysDataIn,
    output SysDataOut, SysDataOE, SysReady, SysBusy
  );
endinterface

// File: rtl/sysmem_array.sv
// Single-port DEPTH x 32 word RAM: synchronous write, registered read with read enable.
module sysmem_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Output register holds between reads so the bus data stays stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_reg <= 32'd0;
    end else if (re) begin
      rdata_reg <= mem[addr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/sys_mem_responder.sv
// Sys* bus memory responder: latency-delayed line read bursts and single-word writes.
// Optional SYSMEM_STATS_EN adds rd_cnt/wr_cnt completion counters.
module sys_mem_responder
  import sysbus_pkg::*;
#(
  parameter int DEPTH      = SYSMEM_DEPTH,
  parameter int LINE_WORDS = SYSMEM_LINE_WORDS,
  parameter int LATENCY    = SYSMEM_LATENCY
) (
  input  logic               clk,
  input  logic               rst,
  sys_mem_responder_if.slave bus
`ifdef SYSMEM_STATS_EN
  ,
  output logic [31:0]        rd_cnt,
  output logic [31:0]        wr_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(LATENCY + 1);
  localparam int BW = $clog2(LINE_WORDS) + 1;
  localparam logic [AW-1:0] LINE_MASK = ~AW'(LINE_WORDS - 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_WORDS - 1);

  sysmem_state_t state_reg;
  logic [AW-1:0] idx_reg;
  logic [AW-1:0] base_reg;
  logic          rw_reg;
  logic [31:0]   wdata_reg;
  logic [LW-1:0] lat_cnt_reg;
  logic [BW-1:0] beat_reg;
  logic          ready_reg;
  logic          oe_reg;
  logic          busy_reg;

  logic [AW-1:0] req_idx;
  logic          ram_we;
  logic          ram_re;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_q;

  assign req_idx = bus.SysAddress[AW+1:2];

  // The RAM read is registered, so each beat's address goes out one cycle early.
  always_comb begin
    ram_re   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = base_reg + AW'(beat_reg) + AW'(1);
    case (state_reg)
      IDLE: begin
        if (LATENCY == 1 && bus.SysStrobe && bus.SysRW == SYS_READ) begin
          ram_re   = 1'b1;
          ram_addr = req_idx & LINE_MASK;
        end
      end
      WAIT: begin
        if (lat_cnt_reg <= LW'(1) && rw_reg == SYS_READ) begin
          ram_re   = 1'b1;
          ram_addr = base_reg;
        end
      end
      RBURST:  ram_re = (beat_reg != LAST_BEAT);
      WCOMMIT: begin
        ram_we   = !rst;
        ram_addr = idx_reg;
      end
      default: ;
    endcase
  end

  sysmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (wdata_reg),
    .rdata (ram_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      base_reg    <= '0;
      rw_reg      <= SYS_READ;
      wdata_reg   <= 32'd0;
      lat_cnt_reg <= '0;
      beat_reg    <= '0;
      ready_reg   <= 1'b0;
      oe_reg      <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.SysStrobe) begin
            idx_reg     <= req_idx;
            base_reg    <= req_idx & LINE_MASK;
            rw_reg      <= bus.SysRW;
            wdata_reg   <= bus.SysDataIn;
            lat_cnt_reg <= LW'(LATENCY - 1);
            beat_reg    <= '0;
            busy_reg    <= 1'b1;
            if (LATENCY == 1) begin
              state_reg <= (bus.SysRW == SYS_WRITE) ? WCOMMIT : RBURST;
              ready_reg <= 1'b1;
              oe_reg    <= (bus.SysRW == SYS_READ);
            end else begin
              state_reg <= WAIT;
            end
          end
        end
        WAIT: begin
          lat_cnt_reg <= lat_cnt_reg - LW'(1);
          // Leave on the edge where the counter reaches zero.
          if (lat_cnt_reg <= LW'(1)) begin
            state_reg <= (rw_reg == SYS_WRITE) ? WCOMMIT : RBURST;
            ready_reg <= 1'b1;
            oe_reg    <= (rw_reg == SYS_READ);
          end
        end
        RBURST: begin
          if (beat_reg == LAST_BEAT) begin
            state_reg <= IDLE;
            beat_reg  <= '0;
            ready_reg <= 1'b0;
            oe_reg    <= 1'b0;
            busy_reg  <= 1'b0;
          end else begin
            beat_reg <= beat_reg + BW'(1);
          end
        end
        WCOMMIT: begin
          state_reg <= IDLE;
          ready_reg <= 1'b0;
          busy_reg  <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.SysDataOut = ram_q;
  assign bus.SysDataOE  = oe_reg;
  assign bus.SysReady   = ready_reg;
  assign bus.SysBusy    = busy_reg;

`ifdef SYSMEM_STATS_EN
  logic [31:0] rd_cnt_reg;
  logic [31:0] wr_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_reg <= 32'd0;
      wr_cnt_reg <= 32'd0;
    end else begin
      if (state_reg == RBURST && beat_reg == LAST_BEAT) begin
        rd_cnt_reg <= rd_cnt_reg + 32'd1;
      end
      if (state_reg == WCOMMIT) begin
        wr_cnt_reg <= wr_cnt_reg + 32'd1;
      end
    end
  end

  assign rd_cnt = rd_cnt_reg;
  assign wr_cnt = wr_cnt_reg;
`endif

endmodule

// File: tb/tb_sys_mem_responder.sv
// Directed bench for sys_mem_responder: a LATENCY=3 instance driven from a vector table
// plus hand sequences, and a LATENCY=1 instance for the short-latency and alias cases.
module tb_sys_mem_responder;
  import sysbus_pkg::*;

  localparam int LAT1 = 3;
  localparam int LWD  = 4;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   exp_rd1 = 0;
  int   exp_wr1 = 0;

  always #5 clk = ~clk;

  sys_mem_responder_if bus1 ();
  sys_mem_responder_if bus2 ();

`ifdef SYSMEM_STATS_EN
  logic [31:0] rd_cnt1, wr_cnt1, rd_cnt2, wr_cnt2;
`endif

  sys_mem_responder #(.DEPTH(1024), .LINE_WORDS(LWD), .LATENCY(LAT1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
`ifdef SYSMEM_STATS_EN
    , .rd_cnt (rd_cnt1), .wr_cnt (wr_cnt1)
`endif
  );

  sys_mem_responder #(.DEPTH(1024), .LINE_WORDS(LWD), .LATENCY(1)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
`ifdef SYSMEM_STATS_EN
    , .rd_cnt (rd_cnt2), .wr_cnt (wr_cnt2)
`endif
  );

  typedef struct {
    string             name;
    logic              rw;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic [3:0][31:0]  exp_b;
  } vec_t;

  vec_t vecs [16];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Full transaction on dut1, strobe in the current cycle, cycle-exact checks to the idle cycle.
  task automatic txn(input string name, input logic rw, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [3:0][31:0] exp_b);
    bus1.SysStrobe = 1'b1;
    bus1.SysRW = rw;
    bus1.SysAddress = addr;
    bus1.SysDataIn = wd;
    step();
    bus1.SysStrobe = 1'b0;
    for (int c = 1; c < LAT1; c++) begin
      chk({name, "/wait_ready"}, 32'(bus1.SysReady), 32'd0);
      chk({name, "/wait_busy"}, 32'(bus1.SysBusy), 32'd1);
      chk({name, "/wait_oe"}, 32'(bus1.SysDataOE), 32'd0);
      step();
    end
    if (rw == SYS_WRITE) begin
      chk({name, "/wr_ready"}, 32'(bus1.SysReady), 32'd1);
      chk({name, "/wr_oe"}, 32'(bus1.SysDataOE), 32'd0);
      chk({name, "/wr_busy"}, 32'(bus1.SysBusy), 32'd1);
      step();
      exp_wr1++;
    end else begin
      for (int k = 0; k < LWD; k++) begin
        chk({name, "/rd_ready"}, 32'(bus1.SysReady), 32'd1);
        chk({name, "/rd_oe"}, 32'(bus1.SysDataOE), 32'd1);
        chk({name, "/rd_data"}, bus1.SysDataOut, exp_b[k]);
        step();
      end
      exp_rd1++;
    end
    chk({name, "/end_ready"}, 32'(bus1.SysReady), 32'd0);
    chk({name, "/end_oe"}, 32'(bus1.SysDataOE), 32'd0);
    chk({name, "/end_busy"}, 32'(bus1.SysBusy), 32'd0);
    $display("txn %s rw=%0d addr=%h wdata=%h", name, rw, addr, wd);
  endtask

  initial begin
    int beats;
    int guard;
    logic [3:0][31:0] held_exp;

    vecs[0]  = '{"w44",  SYS_WRITE, 32'h44,   32'h000000A1, '0};
    vecs[1]  = '{"w48",  SYS_WRITE, 32'h48,   32'h000000A2, '0};
    vecs[2]  = '{"w4c",  SYS_WRITE, 32'h4C,   32'h000000A3, '0};
    vecs[3]  = '{"w40",  SYS_WRITE, 32'h40,   32'hDEADBEEF, '0};
    vecs[4]  = '{"r44",  SYS_READ,  32'h44,   32'h0, {32'hA3, 32'hA2, 32'hA1, 32'hDEADBEEF}};
    vecs[5]  = '{"w20",  SYS_WRITE, 32'h20,   32'h00000011, '0};
    vecs[6]  = '{"w24",  SYS_WRITE, 32'h24,   32'h00000022, '0};
    vecs[7]  = '{"w28",  SYS_WRITE, 32'h28,   32'h00000033, '0};
    vecs[8]  = '{"w2c",  SYS_WRITE, 32'h2C,   32'h00000044, '0};
    vecs[9]  = '{"r2c",  SYS_READ,  32'h2C,   32'h0, {32'h44, 32'h33, 32'h22, 32'h11}};
    vecs[10] = '{"r1028_alias", SYS_READ, 32'h1028, 32'h0, {32'h44, 32'h33, 32'h22, 32'h11}};
    vecs[11] = '{"w80",  SYS_WRITE, 32'h80,   32'h00001234, '0};
    vecs[12] = '{"w84",  SYS_WRITE, 32'h84,   32'h000000B1, '0};
    vecs[13] = '{"w88",  SYS_WRITE, 32'h88,   32'h000000B2, '0};
    vecs[14] = '{"w8c",  SYS_WRITE, 32'h8C,   32'h000000B3, '0};
    vecs[15] = '{"r80",  SYS_READ,  32'h80,   32'h0, {32'hB3, 32'hB2, 32'hB1, 32'h1234}};

    // Reset with strobes held high: nothing may be accepted.
    rst = 1'b1;
    bus1.SysStrobe = 1'b1; bus1.SysRW = SYS_READ; bus1.SysAddress = 32'h0; bus1.SysDataIn = 32'h0;
    bus2.SysStrobe = 1'b1; bus2.SysRW = SYS_READ; bus2.SysAddress = 32'h0; bus2.SysDataIn = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    bus1.SysStrobe = 1'b0;
    bus2.SysStrobe = 1'b0;
    chk("reset/ready", 32'(bus1.SysReady), 32'd0);
    chk("reset/oe", 32'(bus1.SysDataOE), 32'd0);
    chk("reset/busy", 32'(bus1.SysBusy), 32'd0);
    chk("reset/data", bus1.SysDataOut, 32'd0);
    step();
    chk("reset/busy_after", 32'(bus1.SysBusy), 32'd0);
    chk("reset/busy2_after", 32'(bus2.SysBusy), 32'd0);

    for (int i = 0; i < 16; i++) begin
      txn(vecs[i].name, vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].exp_b);
    end

    // Strobe held through WAIT and RBURST: one burst only, then accepted on the first IDLE cycle.
    held_exp = {32'h44, 32'h33, 32'h22, 32'h11};
    bus1.SysStrobe = 1'b1; bus1.SysRW = SYS_READ; bus1.SysAddress = 32'h2C; bus1.SysDataIn = 32'h0;
    step();
    bus1.SysRW = SYS_WRITE; bus1.SysAddress = 32'h200; bus1.SysDataIn = 32'h77;
    beats = 0;
    guard = 0;
    while (bus1.SysBusy && guard < 20) begin
      if (bus1.SysReady) begin
        if (beats < LWD) chk("held/beat_data", bus1.SysDataOut, held_exp[beats]);
        beats++;
      end
      guard++;
      step();
    end
    chk("held/no_timeout", 32'(guard < 20), 32'd1);
    chk("held/beat_count", 32'(beats), 32'd4);
    exp_rd1++;
    step();
    bus1.SysStrobe = 1'b0;
    chk("held/accept_first_idle", 32'(bus1.SysBusy), 32'd1);
    guard = 0;
    while (bus1.SysBusy && guard < 20) begin
      guard++;
      step();
    end
    chk("held/write_done", 32'(guard < 20), 32'd1);
    exp_wr1++;
    $display("txn held_strobe beats=%0d", beats);

`ifdef SYSMEM_STATS_EN
    chk("stats1/rd", rd_cnt1, 32'(exp_rd1));
    chk("stats1/wr", wr_cnt1, 32'(exp_wr1));
`endif

    // Abort a write in WAIT.
    bus1.SysStrobe = 1'b1; bus1.SysRW = SYS_WRITE; bus1.SysAddress = 32'h80; bus1.SysDataIn = 32'h5555;
    step();
    bus1.SysStrobe = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_wait/ready", 32'(bus1.SysReady), 32'd0);
    chk("abort_wait/busy", 32'(bus1.SysBusy), 32'd0);
    chk("abort_wait/oe", 32'(bus1.SysDataOE), 32'd0);
    chk("abort_wait/data", bus1.SysDataOut, 32'd0);
    $display("txn abort_in_wait addr=00000080");

    // Abort a write during its commit cycle.
    bus1.SysStrobe = 1'b1; bus1.SysRW = SYS_WRITE; bus1.SysAddress = 32'h84; bus1.SysDataIn = 32'h6666;
    step();
    bus1.SysStrobe = 1'b0;
    step();
    step();
    chk("abort_commit/ready", 32'(bus1.SysReady), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_commit/busy", 32'(bus1.SysBusy), 32'd0);
    chk("abort_commit/ready_low", 32'(bus1.SysReady), 32'd0);
    $display("txn abort_in_commit addr=00000084");
    exp_rd1 = 0;
    exp_wr1 = 0;

    txn("r80_after_abort", SYS_READ, 32'h80, 32'h0, {32'hB3, 32'hB2, 32'hB1, 32'h1234});

`ifdef SYSMEM_STATS_EN
    chk("stats1/rd_after_abort", rd_cnt1, 32'(exp_rd1));
    chk("stats1/wr_after_abort", wr_cnt1, 32'(exp_wr1));
`endif

    // LATENCY=1 instance: write word 0, then two reads through the 0x1000 alias.
    bus2.SysStrobe = 1'b1; bus2.SysRW = SYS_WRITE; bus2.SysAddress = 32'h0; bus2.SysDataIn = 32'hCAFE0000;
    step();
    bus2.SysStrobe = 1'b0;
    chk("lat1_w/ready", 32'(bus2.SysReady), 32'd1);
    chk("lat1_w/oe", 32'(bus2.SysDataOE), 32'd0);
    step();
    chk("lat1_w/ready_low", 32'(bus2.SysReady), 32'd0);
    chk("lat1_w/busy_low", 32'(bus2.SysBusy), 32'd0);
    $display("txn lat1 write addr=00000000 wdata=cafe0000");
    for (int r = 0; r < 2; r++) begin
      bus2.SysStrobe = 1'b1; bus2.SysRW = SYS_READ; bus2.SysAddress = 32'h1000;
      step();
      bus2.SysStrobe = 1'b0;
      chk("lat1_r/ready", 32'(bus2.SysReady), 32'd1);
      chk("lat1_r/oe", 32'(bus2.SysDataOE), 32'd1);
      chk("lat1_r/beat0", bus2.SysDataOut, 32'hCAFE0000);
      for (int k = 1; k < LWD; k++) begin
        step();
        chk("lat1_r/ready_beat", 32'(bus2.SysReady), 32'd1);
      end
      step();
      chk("lat1_r/busy_low", 32'(bus2.SysBusy), 32'd0);
      chk("lat1_r/oe_low", 32'(bus2.SysDataOE), 32'd0);
      $display("txn lat1 read addr=00001000 pass=%0d", r);
    end

`ifdef SYSMEM_STATS_EN
    chk("stats2/rd", rd_cnt2, 32'd2);
    chk("stats2/wr", wr_cnt2, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
